// File: rtl/wb_retire_unit.sv
// Write-back retirement unit: merges ALU results and cache load responses onto the
// single register-file write port through a small in-order queue, with RAW hazard detection.
module wb_retire_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  dec_rd,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        stall,
  output logic        hazard,
  output logic        idle,
  output logic        err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       q_rd_q   [DEPTH];
  logic [4:0]       q_rd_d   [DEPTH];
  logic [31:0]      q_data_q [DEPTH];
  logic [31:0]      q_data_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ld_pending_q, ld_pending_d;
  logic [4:0]       ld_pending_rd_q, ld_pending_rd_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             err_q, err_d;

  logic             full;
  logic             q_empty;
  logic             alu_acc;
  logic             resp_ok;
  logic             resp_write;
  logic             pop;
  logic             bypass;
  logic             push;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign q_empty = (count_q == '0);

  always_comb begin
    q_rd_d          = q_rd_q;
    q_data_d        = q_data_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    ld_pending_d    = ld_pending_q;
    ld_pending_rd_d = ld_pending_rd_q;
    err_d           = err_q;
    rf_we_d         = 1'b0;
    rf_addr_d       = 5'd0;
    rf_wdata_d      = 32'd0;

    alu_acc    = alu_valid && !full && (alu_rd != 5'd0);
    resp_ok    = ld_resp_valid && ld_pending_q;
    // A discarded load (rd 0) consumes its response but leaves the port free.
    resp_write = resp_ok && (ld_pending_rd_q != 5'd0);
    pop        = !resp_write && !q_empty;
    bypass     = !resp_write && q_empty && alu_acc;
    push       = alu_acc && !bypass;

    if (resp_write) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = ld_pending_rd_q;
      rf_wdata_d = ld_resp_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = q_rd_q[rd_ptr_q];
      rf_wdata_d = q_data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = alu_rd;
      rf_wdata_d = alu_data;
    end

    if (push) begin
      q_rd_d[wr_ptr_q]   = alu_rd;
      q_data_d[wr_ptr_q] = alu_data;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (resp_ok) begin
      ld_pending_d = 1'b0;
    end
    if (ld_issue && (!ld_pending_q || ld_resp_valid)) begin
      ld_pending_d    = 1'b1;
      ld_pending_rd_d = ld_rd;
    end

    if ((ld_issue && ld_pending_q && !ld_resp_valid) || (ld_resp_valid && !ld_pending_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_q[i]   <= 5'd0;
        q_data_q[i] <= 32'd0;
      end
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      ld_pending_q    <= 1'b0;
      ld_pending_rd_q <= 5'd0;
      rf_we_q         <= 1'b0;
      rf_addr_q       <= 5'd0;
      rf_wdata_q      <= 32'd0;
      err_q           <= 1'b0;
    end else begin
      q_rd_q          <= q_rd_d;
      q_data_q        <= q_data_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      ld_pending_q    <= ld_pending_d;
      ld_pending_rd_q <= ld_pending_rd_d;
      rf_we_q         <= rf_we_d;
      rf_addr_q       <= rf_addr_d;
      rf_wdata_q      <= rf_wdata_d;
      err_q           <= err_d;
    end
  end

  // Queued and in-flight writes only conflict with sources; the pending load also blocks WAW.
  logic [PTR_W-1:0] slot;
  always_comb begin
    hazard = 1'b0;
    slot   = rd_ptr_q;
    if (ld_pending_q && (ld_pending_rd_q != 5'd0) &&
        ((rs1 == ld_pending_rd_q) || (rs2 == ld_pending_rd_q) || (dec_rd == ld_pending_rd_q))) begin
      hazard = 1'b1;
    end
    if (rf_we_q && (rf_addr_q != 5'd0) && ((rs1 == rf_addr_q) || (rs2 == rf_addr_q))) begin
      hazard = 1'b1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (q_rd_q[slot] != 5'd0) &&
          ((rs1 == q_rd_q[slot]) || (rs2 == q_rd_q[slot]))) begin
        hazard = 1'b1;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;
  assign stall    = full;
  assign idle     = q_empty && !ld_pending_q && !rf_we_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed self-checking bench for wb_retire_unit: bypass, load merge, queue fill/stall,
// rd 0 drops, protocol errors and mid-operation reset.
module tb_wb_retire_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  rs1, rs2, dec_rd;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        stall, hazard, idle, err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  wb_retire_unit #(.DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .rs1(rs1), .rs2(rs2), .dec_rd(dec_rd),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .stall(stall), .hazard(hazard), .idle(idle), .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic li, input logic [4:0] lrd,
                               input logic rv, input logic [31:0] rdata);
    alu_valid     = av;
    alu_rd        = ard;
    alu_data      = adata;
    ld_issue      = li;
    ld_rd         = lrd;
    ld_resp_valid = rv;
    ld_resp_data  = rdata;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    reset_n = 1'b1;
    idleCycle();
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_rd = 5'd0; ld_resp_valid = 1'b0; ld_resp_data = 32'd0;
    rs1 = 5'd0; rs2 = 5'd0; dec_rd = 5'd0;
    #12;
    checkOutput("reset_rf_we",    32'(rf_we),    32'd0);
    checkOutput("reset_rf_addr",  32'(rf_addr),  32'd0);
    checkOutput("reset_rf_wdata", rf_wdata,      32'd0);
    checkOutput("reset_stall",    32'(stall),    32'd0);
    checkOutput("reset_hazard",   32'(hazard),   32'd0);
    checkOutput("reset_idle",     32'(idle),     32'd1);
    checkOutput("reset_err",      32'(err),      32'd0);
    reset_n = 1'b1;
    idleCycle();

    $display("[TB] ALU bypass on empty queue");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'd0);
    checkOutput("bypass_we",   32'(rf_we),   32'd1);
    checkOutput("bypass_addr", 32'(rf_addr), 32'd5);
    checkOutput("bypass_data", rf_wdata,     32'hDEADBEEF);
    idleCycle();
    checkOutput("bypass_we_after", 32'(rf_we), 32'd0);
    checkOutput("bypass_idle",     32'(idle),  32'd1);

    $display("[TB] load response merged ahead of ALU result");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
    rs1 = 5'd7;
    #1;
    checkOutput("ld_hazard_c1", 32'(hazard), 32'd1);
    checkOutput("ld_idle_c1",   32'(idle),   32'd0);
    idleCycle();
    checkOutput("ld_hazard_c2", 32'(hazard), 32'd1);
    idleCycle();
    checkOutput("ld_hazard_c3", 32'(hazard), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 1'b1, 32'h12345678);
    checkOutput("ld_we",     32'(rf_we),   32'd1);
    checkOutput("ld_addr",   32'(rf_addr), 32'd7);
    checkOutput("ld_data",   rf_wdata,     32'h12345678);
    checkOutput("ld_hazard_wr", 32'(hazard), 32'd1);
    idleCycle();
    checkOutput("alu_after_ld_addr", 32'(rf_addr), 32'd3);
    checkOutput("alu_after_ld_data", rf_wdata,     32'h1);
    checkOutput("ld_hazard_clear",   32'(hazard),  32'd0);
    rs1 = 5'd0;
    idleCycle();
    checkOutput("ld_idle_end", 32'(idle), 32'd1);

    $display("[TB] back-to-back load responses fill the queue");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'(k), 32'h100 + 32'(k), 1'b1, 5'd9, 1'b1, 32'hA0000000 + 32'(k));
      checkOutput($sformatf("fill_addr_%0d", k),  32'(rf_addr), 32'd9);
      checkOutput($sformatf("fill_data_%0d", k),  rf_wdata,     32'hA0000000 + 32'(k));
      checkOutput($sformatf("fill_stall_%0d", k), 32'(stall),   (k == 4) ? 32'd1 : 32'd0);
    end
    rs2 = 5'd3;
    #1;
    checkOutput("haz_queue_rs2", 32'(hazard), 32'd1);
    rs2 = 5'd0; dec_rd = 5'd3;
    #1;
    checkOutput("haz_queue_decrd", 32'(hazard), 32'd0);
    dec_rd = 5'd9;
    #1;
    checkOutput("haz_pending_decrd", 32'(hazard), 32'd1);
    dec_rd = 5'd0;
    applyStimulus(1'b1, 5'd5, 32'h105, 1'b1, 5'd9, 1'b1, 32'hA0000005);
    checkOutput("full_ld_addr",  32'(rf_addr), 32'd9);
    checkOutput("full_ld_data",  rf_wdata,     32'hA0000005);
    checkOutput("full_ld_stall", 32'(stall),   32'd1);
    applyStimulus(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 1'b1, 32'hA0000006);
    checkOutput("full_ld2_data",  rf_wdata,   32'hA0000006);
    checkOutput("full_ld2_stall", 32'(stall), 32'd1);
    applyStimulus(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 1'b0, 32'd0);
    checkOutput("drain_addr_1",  32'(rf_addr), 32'd1);
    checkOutput("drain_data_1",  rf_wdata,     32'h101);
    checkOutput("drain_stall_1", 32'(stall),   32'd0);
    applyStimulus(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 1'b0, 32'd0);
    checkOutput("drain_addr_2", 32'(rf_addr), 32'd2);
    applyStimulus(1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 1'b0, 32'd0);
    checkOutput("drain_addr_3", 32'(rf_addr), 32'd3);
    checkOutput("drain_data_3", rf_wdata,     32'h103);
    for (int k = 4; k <= 6; k++) begin
      idleCycle();
      checkOutput($sformatf("drain_addr_%0d", k), 32'(rf_addr), 32'(k));
      checkOutput($sformatf("drain_data_%0d", k), rf_wdata,     32'h100 + 32'(k));
    end
    idleCycle();
    checkOutput("drain_we_end",   32'(rf_we), 32'd0);
    checkOutput("drain_idle_end", 32'(idle),  32'd1);

    $display("[TB] rd 0 writes are dropped");
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 32'd0);
    checkOutput("x0_we_c1",   32'(rf_we), 32'd0);
    checkOutput("x0_idle_c1", 32'(idle),  32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h55);
    checkOutput("x0_we_c2",   32'(rf_we), 32'd0);
    checkOutput("x0_idle_c2", 32'(idle),  32'd1);
    checkOutput("x0_err",     32'(err),   32'd0);

    $display("[TB] protocol errors");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h77);
    checkOutput("err_resp",    32'(err),   32'd1);
    checkOutput("err_resp_we", 32'(rf_we), 32'd0);
    idleCycle();
    checkOutput("err_sticky", 32'(err), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hCAFE);
    checkOutput("err_keep_addr", 32'(rf_addr), 32'd10);
    checkOutput("err_keep_data", rf_wdata,     32'hCAFE);
    idleCycle();
    checkOutput("err_idle",    32'(idle), 32'd1);
    checkOutput("err_sticky2", 32'(err),  32'd1);

    $display("[TB] reset with queued and pending writes");
    doReset();
    checkOutput("rst_err_clear", 32'(err), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 32'd0);
    for (int k = 13; k <= 15; k++) begin
      applyStimulus(1'b1, 5'(k), 32'(k), 1'b1, 5'd12, 1'b1, 32'hB0 + 32'(k));
    end
    checkOutput("pre_rst_addr", 32'(rf_addr), 32'd12);
    checkOutput("pre_rst_idle", 32'(idle),    32'd0);
    checkOutput("pre_rst_stall", 32'(stall),  32'd0);
    alu_valid = 1'b0; ld_issue = 1'b0; ld_resp_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_we",    32'(rf_we),   32'd0);
    checkOutput("async_rst_addr",  32'(rf_addr), 32'd0);
    checkOutput("async_rst_wdata", rf_wdata,     32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_idle", 32'(idle), 32'd1);
    rs1 = 5'd13;
    #1;
    checkOutput("post_rst_hazard", 32'(hazard), 32'd0);
    rs1 = 5'd0;
    for (int k = 0; k < 5; k++) begin
      idleCycle();
      checkOutput($sformatf("post_rst_we_%0d", k), 32'(rf_we), 32'd0);
    end
    checkOutput("post_rst_idle_end", 32'(idle), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
